// File: rtl/mpt_plb.sv
// mpt_plb: fully-associative protection lookaside buffer caching MPT walker results per SPA page
package mpt_plb_pkg;
  typedef logic [33:0] spa_t_u;
  typedef enum logic [1:0] {ACC_READ = 2'd0, ACC_WRITE = 2'd1, ACC_EXEC = 2'd2} mpt_access_e;
  typedef enum logic [1:0] {FMT_NONE = 2'd0, FMT_RSVD = 2'd1, FMT_LEVEL = 2'd2, FMT_MODE = 2'd3} page_format_fault_e;
  typedef struct packed {logic [2:0] perms;} plb_entry_t;
endpackage

module mpt_plb import mpt_plb_pkg::*; #(
  parameter int N_ENTRIES    = 8,
  parameter int PAGE_SHIFT   = 12,
  parameter int WALK_TIMEOUT = 1023
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               mpt_en_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  spa_t_u             req_spa_i,
  input  mpt_access_e        req_access_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic               resp_allow_o,
  output logic               resp_fault_o,
  output page_format_fault_e resp_format_error_o,
  output logic               ptw_flush_o,
  output logic               ptw_enable_o,
  output logic               ptw_addr_valid_o,
  output spa_t_u             ptw_spa_o,
  output mpt_access_e        ptw_access_type_o,
  input  logic               ptw_busy_i,
  input  logic               ptw_valid_i,
  input  logic               ptw_allow_i,
  input  logic               ptw_fault_i,
  input  page_format_fault_e ptw_format_error_i,
  input  plb_entry_t         ptw_entry_i
);
  localparam int TW = $bits(spa_t_u) - PAGE_SHIFT;
  localparam int CW = $clog2(WALK_TIMEOUT + 1);
  localparam int IW = $clog2(N_ENTRIES);
  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WALK, S_RESP} state_e;
  state_e             r_state, w_next;
  spa_t_u             r_spa;
  mpt_access_e        r_acc;
  logic [N_ENTRIES-1:0] r_valid;
  logic [TW-1:0]      r_tag [N_ENTRIES];
  logic [2:0]         r_perms [N_ENTRIES];
  logic [IW-1:0]      r_rr, w_free_idx, w_fill_idx;
  logic [CW-1:0]      r_cnt;
  logic               r_allow, r_fault, w_allow, w_fault;
  page_format_fault_e r_fmt, w_fmt;
  logic [TW-1:0]      w_tag;
  logic [2:0]         w_hit_perms;
  logic               w_hit, w_free, w_hit_allow, w_done, w_clean, w_walk_allow, w_timeout, w_fill;
  logic               w_unused;
  function automatic logic perm_bit(input logic [2:0] p, input mpt_access_e a);
    return a == ACC_EXEC ? p[2] : a == ACC_WRITE ? p[1] : p[0];
  endfunction
  assign w_tag = r_spa[$bits(spa_t_u)-1:PAGE_SHIFT];
  always_comb begin
    w_hit = 1'b0;
    w_hit_perms = '0;
    w_free = 1'b0;
    w_free_idx = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (r_valid[i] && r_tag[i] == w_tag) begin
        w_hit = 1'b1;
        w_hit_perms |= r_perms[i];
      end
      if (!r_valid[i]) begin
        w_free = 1'b1;
        w_free_idx = IW'(i);
      end
    end
  end
  assign w_hit_allow  = perm_bit(w_hit_perms, r_acc);
  assign w_done       = ptw_valid_i | ptw_fault_i | (ptw_format_error_i != FMT_NONE);
  assign w_clean      = ptw_valid_i & ~ptw_fault_i & (ptw_format_error_i == FMT_NONE);
  assign w_walk_allow = ptw_allow_i & w_clean;
  assign w_timeout    = r_cnt == CW'(WALK_TIMEOUT);
  assign w_fill       = (r_state == S_WALK) & w_clean & ~flush_i;
  assign w_fill_idx   = w_free ? w_free_idx : r_rr;
  always_comb begin
    w_next = r_state;
    w_allow = r_allow;
    w_fault = r_fault;
    w_fmt = r_fmt;
    case (r_state)
      S_IDLE: w_next = req_valid_i ? S_LOOKUP : S_IDLE;
      S_LOOKUP: begin
        w_next = (!mpt_en_i || w_hit) ? S_RESP : S_WALK;
        w_allow = !mpt_en_i || w_hit_allow;
        w_fault = mpt_en_i && !w_hit_allow;
        w_fmt = FMT_NONE;
      end
      S_WALK: begin
        if (w_done) begin
          w_next = S_RESP;
          w_allow = w_walk_allow;
          w_fault = ~w_walk_allow;
          w_fmt = ptw_format_error_i;
        end else if (w_timeout) begin
          w_next = S_RESP;
          w_allow = 1'b0;
          w_fault = 1'b1;
          w_fmt = FMT_NONE;
        end
      end
      S_RESP: w_next = resp_ready_i ? S_IDLE : S_RESP;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_rr <= '0;
      r_cnt <= '0;
      r_allow <= 1'b0;
      r_fault <= 1'b0;
      r_fmt <= FMT_NONE;
      r_spa <= '0;
      r_acc <= ACC_READ;
    end else begin
      r_state <= w_next;
      r_allow <= w_allow;
      r_fault <= w_fault;
      r_fmt <= w_fmt;
      r_cnt <= (r_state == S_WALK) ? r_cnt + CW'(1) : '0;
      if (r_state == S_IDLE && req_valid_i) begin
        r_spa <= req_spa_i;
        r_acc <= req_access_i;
      end
      if (flush_i) r_valid <= '0;
      else if (w_fill) r_valid[w_fill_idx] <= 1'b1;
      if (w_fill) begin
        r_tag[w_fill_idx] <= w_tag;
        r_perms[w_fill_idx] <= ptw_entry_i.perms;
        if (!w_free) r_rr <= r_rr + IW'(1);
      end
    end
  end
  assign w_unused            = ptw_busy_i;
  assign req_ready_o         = r_state == S_IDLE;
  assign resp_valid_o        = r_state == S_RESP;
  assign resp_allow_o        = resp_valid_o & r_allow;
  assign resp_fault_o        = resp_valid_o & r_fault;
  assign resp_format_error_o = resp_valid_o ? r_fmt : FMT_NONE;
  assign ptw_flush_o         = flush_i;
  assign ptw_enable_o        = r_state == S_WALK;
  assign ptw_addr_valid_o    = r_state == S_WALK;
  assign ptw_spa_o           = r_spa;
  assign ptw_access_type_o   = r_acc;
endmodule

// File: tb/tb_mpt_plb.sv
// tb_mpt_plb: directed and random access checks against a page-table cache model
module tb_mpt_plb;
  import mpt_plb_pkg::*;
  logic clk_i = 1'b0;
  logic rst_i, flush_i, mpt_en_i, req_valid_i, req_ready_o, resp_valid_o, resp_ready_i;
  logic resp_allow_o, resp_fault_o, ptw_flush_o, ptw_enable_o, ptw_addr_valid_o;
  logic ptw_busy_i, ptw_valid_i, ptw_allow_i, ptw_fault_i;
  spa_t_u req_spa_i, ptw_spa_o;
  mpt_access_e req_access_i, ptw_access_type_o;
  page_format_fault_e resp_format_error_o, ptw_format_error_i;
  plb_entry_t ptw_entry_i;
  int checks = 0, errors = 0;
  bit m_v [8];
  logic [21:0] m_t [8];
  logic [2:0] m_p [8];
  int m_rr;

  mpt_plb dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .mpt_en_i(mpt_en_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_spa_i(req_spa_i),
    .req_access_i(req_access_i), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_allow_o(resp_allow_o), .resp_fault_o(resp_fault_o),
    .resp_format_error_o(resp_format_error_o), .ptw_flush_o(ptw_flush_o),
    .ptw_enable_o(ptw_enable_o), .ptw_addr_valid_o(ptw_addr_valid_o), .ptw_spa_o(ptw_spa_o),
    .ptw_access_type_o(ptw_access_type_o), .ptw_busy_i(ptw_busy_i), .ptw_valid_i(ptw_valid_i),
    .ptw_allow_i(ptw_allow_i), .ptw_fault_i(ptw_fault_i),
    .ptw_format_error_i(ptw_format_error_i), .ptw_entry_i(ptw_entry_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    resp_ready_i = 1'b0;
    ptw_valid_i = 1'b0;
    ptw_fault_i = 1'b0;
    ptw_allow_i = 1'b0;
    ptw_format_error_i = FMT_NONE;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    foreach (m_v[i]) m_v[i] = 1'b0;
    m_rr = 0;
  endtask

  // wmode: 0 clean result, 1 walker fault, 2 format error, 3 silent walker
  // fl: 0 none, 1 flush in the result cycle, 2 flush in the first walk cycle
  task automatic access(input logic [33:0] spa, input int acc, input int wmode, input int wdly,
                        input logic [2:0] wperm, input int wfmt, input int fl);
    logic [21:0] tag;
    int hit, lat, wc, b, idx;
    bit seen, exp_walk, exp_allow, exp_fault, do_flush, do_fill;
    int exp_fmt;
    tag = spa[33:12];
    hit = -1;
    lat = 0;
    wc = 0;
    b = 0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) if (m_v[i] && m_t[i] == tag) hit = i;
    exp_walk = mpt_en_i && hit < 0;
    exp_fmt = 0;
    if (!mpt_en_i) begin
      exp_allow = 1'b1;
      exp_fault = 1'b0;
    end else if (hit >= 0) begin
      exp_allow = m_p[hit][acc];
      exp_fault = !exp_allow;
    end else begin
      exp_allow = wmode == 0 && wperm[acc];
      exp_fault = !exp_allow;
      exp_fmt = wmode == 2 ? wfmt : 0;
    end
    while (!req_ready_o && b < 50) begin
      @(negedge clk_i);
      b++;
    end
    req_spa_i = spa;
    req_access_i = mpt_access_e'(acc);
    req_valid_i = 1'b1;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    while (!seen && lat < 1200) begin
      @(negedge clk_i);
      lat++;
      ptw_valid_i = 1'b0;
      ptw_fault_i = 1'b0;
      ptw_allow_i = 1'b0;
      ptw_format_error_i = FMT_NONE;
      flush_i = 1'b0;
      if (resp_valid_o) seen = 1'b1;
      else if (ptw_enable_o) begin
        wc++;
        if (wc == 1) begin
          chk("walk_spa", ptw_spa_o, spa);
          chk("walk_acc", ptw_access_type_o, acc);
          chk("walk_addr_valid", ptw_addr_valid_o, 1);
          if (fl == 2) flush_i = 1'b1;
        end
        if (wmode != 3 && wc == wdly + 1) begin
          ptw_valid_i = wmode != 2 || wdly[0];
          ptw_fault_i = wmode == 1;
          ptw_allow_i = wmode == 0 ? wperm[acc] : 1'b1;
          ptw_entry_i.perms = wperm;
          ptw_format_error_i = wmode == 2 ? page_format_fault_e'(wfmt) : FMT_NONE;
          if (fl == 1) flush_i = 1'b1;
        end
      end
    end
    chk("resp_valid", seen, 1);
    chk("walked", wc > 0, exp_walk);
    if (seen) begin
      chk("allow", resp_allow_o, exp_allow);
      chk("fault", resp_fault_o, exp_fault);
      chk("fmt", resp_format_error_o, exp_fmt);
      if (!exp_walk) chk("hit_latency", lat, 2);
      if (exp_walk && wmode == 3) chk("timeout_cycles", wc, 1024);
      resp_ready_i = 1'b1;
      @(negedge clk_i);
      resp_ready_i = 1'b0;
      chk("ready_after_resp", req_ready_o, 1);
    end
    if (exp_walk) begin
      do_flush = fl == 2 || (fl == 1 && wmode != 3);
      do_fill = wmode == 0 && fl != 1 && !(fl == 2 && wdly == 0);
      if (do_flush) foreach (m_v[i]) m_v[i] = 1'b0;
      if (do_fill) begin
        idx = -1;
        for (int i = 7; i >= 0; i--) if (!m_v[i]) idx = i;
        if (idx < 0) begin
          idx = m_rr;
          m_rr = (m_rr + 1) % 8;
        end
        m_v[idx] = 1'b1;
        m_t[idx] = tag;
        m_p[idx] = wperm;
      end
    end
  endtask

  initial begin
    ptw_busy_i = 1'b0;
    ptw_entry_i.perms = 3'b000;
    req_spa_i = '0;
    req_access_i = ACC_READ;
    mpt_en_i = 1'b1;
    do_reset();
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_resp_allow", resp_allow_o, 0);
    chk("rst_resp_fault", resp_fault_o, 0);
    chk("rst_resp_fmt", resp_format_error_o, 0);
    chk("rst_ptw_enable", ptw_enable_o, 0);
    chk("rst_ptw_addr_valid", ptw_addr_valid_o, 0);
    access(34'h0_8000_1234, 0, 0, 5, 3'b001, 0, 0);
    access(34'h0_8000_1FFC, 0, 0, 0, 3'b000, 0, 0);
    access(34'h0_8000_1000, 1, 0, 0, 3'b000, 0, 0);
    access(34'h0_9000_0000, 2, 2, 2, 3'b111, 2, 0);
    access(34'h0_9000_0010, 2, 0, 1, 3'b100, 0, 0);
    access(34'h0_9000_0020, 2, 0, 1, 3'b000, 0, 0);
    access(34'h0_A000_0000, 0, 1, 0, 3'b111, 0, 0);
    do_reset();
    for (int p = 0; p < 9; p++) access(34'h0_1000_0000 + 34'(p << 12), 0, 0, 1, 3'b001, 0, 0);
    access(34'h0_1000_1008, 0, 0, 1, 3'b001, 0, 0);
    access(34'h0_1000_0008, 0, 0, 1, 3'b011, 0, 0);
    access(34'h0_3000_0000, 0, 0, 3, 3'b111, 0, 1);
    access(34'h0_1000_1000, 0, 0, 2, 3'b001, 0, 0);
    access(34'h0_3100_0000, 1, 1, 3, 3'b111, 0, 2);
    access(34'h0_1000_1000, 0, 0, 2, 3'b001, 0, 0);
    access(34'h0_3200_0000, 0, 3, 0, 3'b111, 0, 0);
    flush_i = 1'b1;
    #1 chk("ptw_flush", ptw_flush_o, 1);
    @(negedge clk_i);
    flush_i = 1'b0;
    foreach (m_v[i]) m_v[i] = 1'b0;
    mpt_en_i = 1'b0;
    access(34'h0_4000_0000, 1, 0, 0, 3'b000, 0, 0);
    access(34'h0_4000_5000, 2, 0, 0, 3'b000, 0, 0);
    mpt_en_i = 1'b1;
    req_spa_i = 34'h0_ABCD_E000;
    req_access_i = ACC_READ;
    req_valid_i = 1'b1;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("mid_walk_enable", ptw_enable_o, 1);
    rst_i = 1'b1;
    ptw_valid_i = 1'b1;
    ptw_allow_i = 1'b1;
    ptw_entry_i.perms = 3'b111;
    @(negedge clk_i);
    rst_i = 1'b0;
    ptw_valid_i = 1'b0;
    ptw_allow_i = 1'b0;
    chk("rst_walk_resp_valid", resp_valid_o, 0);
    chk("rst_walk_enable", ptw_enable_o, 0);
    chk("rst_walk_ready", req_ready_o, 1);
    foreach (m_v[i]) m_v[i] = 1'b0;
    m_rr = 0;
    access(34'h0_ABCD_E000, 0, 0, 1, 3'b001, 0, 0);
    for (int n = 0; n < 200; n++) begin
      int r;
      int dly;
      r = $urandom_range(0, 9);
      dly = $urandom_range(0, 6);
      mpt_en_i = $urandom_range(0, 9) != 0;
      access(34'h0_2000_0000 + 34'($urandom_range(0, 11) << 12) + 34'($urandom_range(0, 4095)),
             $urandom_range(0, 2), r < 7 ? 0 : r == 7 ? 1 : r == 8 ? 2 : 0, dly,
             3'($urandom_range(0, 7)), $urandom_range(1, 3),
             $urandom_range(0, 15) == 0 ? $urandom_range(1, 2) : 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
